// File: rtl/shared_mem_responder.sv
// Shared-memory responder: round-robin arbitration of per-core load/store
// requests onto one memory, one transaction per IDLE->ACCESS->RESP pass.
module shared_mem_responder #(
  parameter int N_CORES = 4,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_CORES-1:0]          mem_req_ld,
  input  logic [N_CORES-1:0]          mem_req_st,
  input  logic [N_CORES*ADDR_W-1:0]   addr_shared_memory,
  input  logic [N_CORES*DATA_W-1:0]   mem_dat_st,
  output logic [DATA_W-1:0]           mem_dat,
  output logic [N_CORES-1:0]          val_data,
  output logic                        busy,
  output logic [3:0]                  grant_id
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e              state_q, state_d;
  logic [3:0]          grant_q;
  logic                op_st_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   mem_dat_q;
  logic [DATA_W-1:0]   mem [2**ADDR_W];

  logic [N_CORES-1:0]  active;
  logic                sel_vld;
  logic [3:0]          sel;
  logic                sel_st;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;

  assign active = mem_req_ld | mem_req_st;

  // Round-robin search from grant_q+1; descending i lets the nearest core win last.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    sel      = grant_q;
    sel_vld  = 1'b0;
    sel_st   = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = N_CORES; i >= 1; i--) begin
      int idx;
      idx = (int'(grant_q) + i) % N_CORES;
      for (int j = 0; j < N_CORES; j++) begin
        if (j == idx && active[j]) begin
          sel     = 4'(j);
          sel_vld = 1'b1;
        end
      end
    end
    for (int j = 0; j < N_CORES; j++) begin
      if (4'(j) == sel) begin
        sel_st   = mem_req_st[j];
        sel_addr = addr_shared_memory[j*ADDR_W +: ADDR_W];
        sel_data = mem_dat_st[j*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (sel_vld) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= 4'(N_CORES - 1);
      op_st_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      mem_dat_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && sel_vld) begin
        grant_q <= sel;
        op_st_q <= sel_st;
        addr_q  <= sel_addr;
        wdata_q <= sel_data;
      end
      if (state_q == ACCESS && !op_st_q) mem_dat_q <= mem[addr_q];
    end
  end

  // NOTE: storage is deliberately left out of reset so it maps to RAM and keeps its contents.
  always_ff @(posedge clk) begin
    if (!reset && state_q == ACCESS && op_st_q) mem[addr_q] <= wdata_q;
  end

  always_comb begin
    val_data = '0;
    for (int j = 0; j < N_CORES; j++) begin
      val_data[j] = (state_q == RESP) && (grant_q == 4'(j));
    end
    busy     = (state_q != IDLE);
    grant_id = grant_q;
    mem_dat  = mem_dat_q;
  end

endmodule

// File: tb/tb_shared_mem_responder.sv
// Directed bench for shared_mem_responder: a table of single transactions
// plus hand-written reset, round-robin and starvation sequences.
module tb_shared_mem_responder;
  localparam int N  = 4;
  localparam int AW = 12;
  localparam int DW = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      mem_req_ld, mem_req_st;
  logic [N*AW-1:0]   addr_shared_memory;
  logic [N*DW-1:0]   mem_dat_st;
  logic [DW-1:0]     mem_dat;
  logic [N-1:0]      val_data;
  logic              busy;
  logic [3:0]        grant_id;

  int total = 0;
  int bad   = 0;

  shared_mem_responder #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .mem_req_ld(mem_req_ld), .mem_req_st(mem_req_st),
    .addr_shared_memory(addr_shared_memory), .mem_dat_st(mem_dat_st),
    .mem_dat(mem_dat), .val_data(val_data), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           core;
    bit           ld;
    bit           st;
    logic [11:0]  addr;
    logic [7:0]   data;
    logic [7:0]   exp_dat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_core(input int k, input bit ld, input bit st,
                          input logic [11:0] a, input logic [7:0] d);
    mem_req_ld[k] = ld;
    mem_req_st[k] = st;
    addr_shared_memory[k*AW +: AW] = a;
    mem_dat_st[k*DW +: DW] = d;
  endtask

  // Raise a request, drop it at the edge after val_data (E2), watch 8 cycles.
  task automatic run_txn(input int k, input bit ld, input bit st,
                         input logic [11:0] a, input logic [7:0] d,
                         output int pulses, output logic [N-1:0] mask, output int busy_cnt);
    bit dropped;
    @(posedge clk); #1;
    set_core(k, ld, st, a, d);
    pulses = 0; mask = '0; busy_cnt = 0; dropped = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (val_data != '0) begin
        pulses++;
        mask |= val_data;
        if (!dropped) begin
          @(posedge clk); #1;
          set_core(k, 0, 0, '0, '0);
          dropped = 1;
        end
      end
    end
    if (!dropped) set_core(k, 0, 0, '0, '0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  vec_t         vecs [10];
  int           pulses, busy_cnt, served, found;
  logic [N-1:0] mask;
  logic [3:0]   order [16];
  int           cnt [N];

  initial begin
    vecs[0] = '{core: 1, ld: 0, st: 1, addr: 12'h3F0, data: 8'h5A, exp_dat: 8'h00};
    vecs[1] = '{core: 1, ld: 1, st: 0, addr: 12'h3F0, data: 8'h00, exp_dat: 8'h5A};
    vecs[2] = '{core: 2, ld: 1, st: 1, addr: 12'h001, data: 8'hC3, exp_dat: 8'h5A};
    vecs[3] = '{core: 0, ld: 1, st: 0, addr: 12'h001, data: 8'h00, exp_dat: 8'hC3};
    vecs[4] = '{core: 3, ld: 0, st: 1, addr: 12'h010, data: 8'h11, exp_dat: 8'hC3};
    vecs[5] = '{core: 3, ld: 1, st: 0, addr: 12'h010, data: 8'h00, exp_dat: 8'h11};
    vecs[6] = '{core: 1, ld: 0, st: 1, addr: 12'h000, data: 8'h00, exp_dat: 8'h11};
    vecs[7] = '{core: 1, ld: 1, st: 0, addr: 12'h000, data: 8'h00, exp_dat: 8'h00};
    vecs[8] = '{core: 0, ld: 0, st: 1, addr: 12'hFFF, data: 8'hFF, exp_dat: 8'h00};
    vecs[9] = '{core: 2, ld: 1, st: 0, addr: 12'hFFF, data: 8'h00, exp_dat: 8'hFF};

    reset = 1'b1;
    mem_req_ld = '0; mem_req_st = '0;
    addr_shared_memory = '0; mem_dat_st = '0;
    @(negedge clk); @(negedge clk);
    check("rst_val_data", 32'(val_data), 32'h0);
    check("rst_busy",     32'(busy),     32'h0);
    check("rst_mem_dat",  32'(mem_dat),  32'h0);
    check("rst_grant",    32'(grant_id), 32'h3);
    reset = 1'b0;

    // Single transactions, each from an idle block
    for (int i = 0; i < 10; i++) begin
      run_txn(vecs[i].core, vecs[i].ld, vecs[i].st, vecs[i].addr, vecs[i].data,
              pulses, mask, busy_cnt);
      check($sformatf("v%0d_pulses", i),  32'(pulses),   32'd1);
      check($sformatf("v%0d_mask", i),    32'(mask),     32'(1 << vecs[i].core));
      check($sformatf("v%0d_grant", i),   32'(grant_id), 32'(vecs[i].core));
      check($sformatf("v%0d_mem_dat", i), 32'(mem_dat),  32'(vecs[i].exp_dat));
      check($sformatf("v%0d_busy", i),    32'(busy_cnt), 32'd2);
    end

    // Reset during ACCESS of a store: store must be dropped
    @(posedge clk); #1;
    set_core(3, 0, 1, 12'h010, 8'h77);
    @(posedge clk);
    @(negedge clk);
    check("abort_busy_access", 32'(busy), 32'h1);
    reset = 1'b1;
    #1;
    check("abort_busy",    32'(busy),     32'h0);
    check("abort_mem_dat", 32'(mem_dat),  32'h0);
    check("abort_grant",   32'(grant_id), 32'h3);
    set_core(3, 0, 0, '0, '0);
    @(negedge clk);
    check("abort_val", 32'(val_data), 32'h0);
    reset = 1'b0;
    run_txn(3, 1, 0, 12'h010, 8'h00, pulses, mask, busy_cnt);
    check("abort_reload_pulses", 32'(pulses),  32'd1);
    check("abort_reload_data",   32'(mem_dat), 32'h11);

    // Reset in RESP drops val_data at once
    @(posedge clk); #1;
    set_core(1, 1, 0, 12'h3F0, 8'h00);
    found = 0;
    for (int c = 0; c < 6 && found == 0; c++) begin
      @(negedge clk);
      if (val_data != '0) found = 1;
    end
    check("resp_seen", 32'(found), 32'd1);
    reset = 1'b1;
    #1;
    check("resp_reset_val",  32'(val_data), 32'h0);
    check("resp_reset_data", 32'(mem_dat),  32'h0);
    set_core(1, 0, 0, '0, '0);
    @(negedge clk);
    reset = 1'b0;

    // Round-robin: cores 0,2,3 together, each holds until served
    pulse_reset();
    @(posedge clk); #1;
    set_core(0, 1, 0, 12'h3F0, 8'h00);
    set_core(2, 1, 0, 12'h3F0, 8'h00);
    set_core(3, 1, 0, 12'h3F0, 8'h00);
    served = 0;
    for (int c = 0; c < 30 && served < 3; c++) begin
      @(negedge clk);
      if (val_data != '0) begin
        order[served] = grant_id;
        served++;
        @(posedge clk); #1;
        set_core(int'(grant_id), 0, 0, '0, '0);
      end
    end
    check("rr_served", 32'(served), 32'd3);
    check("rr_first",  32'(order[0]), 32'd0);
    check("rr_second", 32'(order[1]), 32'd2);
    check("rr_third",  32'(order[2]), 32'd3);
    check("rr_data",   32'(mem_dat),  32'h5A);
    mem_req_ld = '0; mem_req_st = '0;
    run_txn(0, 1, 0, 12'h3F0, 8'h00, pulses, mask, busy_cnt);
    check("rr_core0_again", 32'(grant_id), 32'd0);
    check("rr_core0_mask",  32'(mask),     32'h1);

    // Starvation: all cores request continuously for 12 transactions
    pulse_reset();
    @(posedge clk); #1;
    for (int k = 0; k < N; k++) set_core(k, 1, 0, 12'h3F0, 8'h00);
    for (int k = 0; k < N; k++) cnt[k] = 0;
    served = 0;
    for (int c = 0; c < 60 && served < 12; c++) begin
      @(negedge clk);
      if (val_data != '0) begin
        order[served] = grant_id;
        cnt[grant_id[1:0]]++;
        served++;
      end
    end
    mem_req_ld = '0; mem_req_st = '0;
    check("starve_served", 32'(served), 32'd12);
    for (int i = 0; i < 12; i++)
      check($sformatf("starve_order%0d", i), 32'(order[i]), 32'(i % N));
    for (int k = 0; k < N; k++)
      check($sformatf("starve_count%0d", k), 32'(cnt[k]), 32'd3);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shared_mem_responder.md
SHARED_MEM_RESPONDER -- requirements
Module: shared_mem_responder

Interface
REQ-001 Parameter N_CORES, default 4, number of requesting gpu cores (2..16).
REQ-002 Parameter ADDR_W, default 12, shared-memory address width.
REQ-003 Parameter DATA_W, default 8, shared-memory data width.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous active-high reset.
REQ-007 mem_req_ld  input  N_CORES  per-core load request, held high until that core's val_data.
REQ-008 mem_req_st  input  N_CORES  per-core store request, held high until that core's val_data.
REQ-009 addr_shared_memory  input  N_CORES*ADDR_W  per-core address, core k at bits [k*ADDR_W +: ADDR_W].
REQ-010 mem_dat_st  input  N_CORES*DATA_W  per-core store data, core k at bits [k*DATA_W +: DATA_W].
REQ-011 mem_dat  output  DATA_W  load data, broadcast to all cores, valid while the granted core's val_data is high.
REQ-012 val_data  output  N_CORES  per-core one-cycle completion pulse, used for loads and stores.
REQ-013 busy  output  1  high in ACCESS and RESP states.
REQ-014 grant_id  output  4  index of the core currently or last served.

Function
REQ-015 Storage SHALL be 2**ADDR_W x DATA_W registers/RAM, not cleared by reset.
REQ-016 FSM states SHALL be IDLE, ACCESS and RESP. Transitions:
  - IDLE->ACCESS when any core has mem_req_ld|mem_req_st set; IDLE holds otherwise.
  - ACCESS->RESP unconditionally.
  - RESP->IDLE unconditionally.
REQ-017 Requester k is "active" when mem_req_ld[k]|mem_req_st[k]; only IDLE samples requests.
REQ-018 Arbitration SHALL be round-robin.
  - Search starts at grant_id+1 modulo N_CORES and selects the first active core.
  - After reset the search starts at core 0.
REQ-019 On IDLE->ACCESS the block SHALL latch grant_id, operation, address and store data of the selected core. Later input changes do not affect the transaction.
REQ-020 If a core asserts both mem_req_ld and mem_req_st, the operation SHALL be a store.
REQ-021 On ACCESS->RESP edge:
  - a store writes the latched data to the latched address;
  - a load registers mem[addr] into mem_dat.
REQ-022 In RESP, val_data[grant_id] SHALL be 1 for exactly one cycle; all other val_data bits stay 0; at most one bit is ever high.
REQ-023 mem_dat SHALL hold its last load value outside RESP; stores SHALL NOT change mem_dat.
REQ-024 Latency: request sampled at edge E0 -> val_data high between E1 and E2 -> core drops request at E2 -> next arbitration at E3. Peak throughput is one transaction per 3 cycles.
REQ-025 RESP SHALL NOT sample requests, so the stale request level present at E2 is never regranted.
REQ-026 A load following a store to the same address SHALL return the stored value, with no bypass hazard.
REQ-027 Address and data widths SHALL be used unextended; no wrap or out-of-range condition exists.
REQ-028 A requester left waiting SHALL be granted within N_CORES-1 other transactions (starvation-free).

Reset
REQ-029 Asserting reset SHALL immediately force:
  - state=IDLE, val_data=0, busy=0, mem_dat=0;
  - grant_id=N_CORES-1, so the first search starts at core 0.
REQ-030 Reset asserted in ACCESS SHALL abort the transaction; a pending store is not written.
REQ-031 Reset in RESP SHALL drop val_data immediately; the core's retry behaviour is out of scope.
REQ-032 Memory contents SHALL survive reset.

Verification
REQ-033 Store/load: core 1 stores 0x5A at 0x3F0, then core 1 loads 0x3F0 -> val_data[1] pulses once for each; load returns mem_dat=0x5A; busy high 2 of 3 cycles.
REQ-034 Round-robin: cores 0,2,3 request simultaneously after reset and hold until served -> grant order 0,2,3; then core 0 alone requests -> granted at next IDLE.
REQ-035 Hold discipline: core holds mem_req_ld one extra cycle past val_data (dropped at E2) -> exactly one val_data pulse, no duplicate grant.
REQ-036 Ld+st both set on core 2 with data 0xC3 at addr 0x001 -> memory[0x001]=0xC3; mem_dat unchanged.
REQ-037 Reset mid-ACCESS during a store of 0x77 to 0x010 (prior content 0x11) -> val_data stays 0; subsequent load of 0x010 returns 0x11.
REQ-038 Starvation: all 4 cores request continuously for 12 transactions -> each core is granted exactly 3 times in rotation 0,1,2,3.
